native_register_arbiter: RTL and testbench
==========================================

NATIVE_REGISTER_ARBITER -- requirements
Module: native_register_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk).
REQ-003 SHALL have, per requester i in {0,1}: req_i in 1 access request; we_i in 1 1=write; addr_i in 2 register select; wdata_i in 32 write data; ack_i out 1 one-cycle completion; rdata_i out 32 read data, valid with ack_i.
REQ-004 SHALL drive native side outputs: count_we, config_we, fifo_we, fifo_re (1 each, one-cycle strobes); count_in 32; en_in, dir_in, ire_in 1 each; fifo_data_in 8.
REQ-005 SHALL take native side inputs: count_out 32; en_out, dir_out, ire_out, lt_1k_out, fifo_empty, fifo_full 1 each; fifo_word_count 8; fifo_data_out 8.

Function
REQ-006 SHALL decode addr: 0 COUNT (RW 32b); 1 CONFIG (bit0 en, bit1 dir, bit2 ire RW; bit3 lt_1k RO); 2 FIFO (write=push, read=pop, bits[7:0]); 3 STATUS (RO: bit0 empty, bit1 full, bits[15:8] word_count); unlisted bits read 0.
REQ-007 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE holds while neither req asserted.
REQ-008 SHALL, in IDLE with any req high, latch winner's we/addr/wdata and go to ACCESS next cycle.
REQ-009 SHALL arbitrate round-robin: single requester wins; both requesting -> requester not granted last wins; after reset requester 0 has priority.
REQ-010 SHALL in ACCESS pulse exactly one strobe for one cycle: COUNT write -> count_we with count_in=wdata; CONFIG write -> config_we with en_in/dir_in/ire_in=wdata[0]/[1]/[2]; FIFO write -> fifo_we with fifo_data_in=wdata[7:0]; FIFO read -> fifo_re.
REQ-011 SHALL suppress fifo_we when fifo_full=1 and fifo_re when fifo_empty=1 in ACCESS; access still completes.
REQ-012 SHALL treat STATUS writes and CONFIG bit3 writes as no-ops; no strobe.
REQ-013 SHALL in RESP assert ack of the granted requester only, for exactly one cycle, with rdata; non-granted ack=0, rdata=0.
REQ-014 SHALL sample register reads (COUNT, CONFIG, STATUS) in ACCESS; FIFO read data sampled from fifo_data_out in RESP (one cycle after fifo_re); suppressed pop returns 0.
REQ-015 SHALL give latency: req seen in IDLE cycle N -> strobe cycle N+1 -> ack cycle N+2; next grant earliest N+3.
REQ-016 SHALL complete a latched access even if req drops before ack; requesters must hold req until ack.
REQ-017 SHALL hold count_in/en_in/dir_in/ire_in/fifo_data_in at last driven value between strobes.

Reset
REQ-018 SHALL on reset=0: FSM to IDLE, all strobes 0, ack_i 0, rdata_i 0, native data outputs 0, priority to requester 0.
REQ-019 SHALL abort an in-flight access when reset asserts in ACCESS or RESP: no strobe or ack issued on that or following cycles.

Configuration
REQ-020 SHALL support macro NATIVE_REGISTER_ARBITER_ERR_EN: when defined adds outputs err_0, err_1 (1b), asserted with ack for FIFO write while full, FIFO read while empty, or STATUS write; else 0.
REQ-021 SHALL, when NATIVE_REGISTER_ARBITER_ERR_EN undefined, omit err ports and logic; all other behaviour identical.

Verification
REQ-022 SHALL verify: req_0 write addr0 wdata=0x0000_03E8 -> count_we=1, count_in=0x3E8 two cycles later ack_0=1.
REQ-023 SHALL verify: req_0 and req_1 asserted continuously from reset, both reading addr0 -> grants alternate 0,1,0,1; each ack spaced 3 cycles.
REQ-024 SHALL verify: FIFO write 0xA5 with fifo_full=1 -> fifo_we stays 0, ack issued, err=1 if ERR_EN.
REQ-025 SHALL verify: FIFO read with fifo_empty=0, fifo_data_out=0x5C after fifo_re -> rdata=0x0000_005C with ack.
REQ-026 SHALL verify: STATUS read with empty=0, full=1, word_count=0x10 -> rdata=0x0000_1002.
REQ-027 SHALL verify: reset=0 during ACCESS of CONFIG write -> no ack, FSM IDLE, outputs zero, next access granted to requester 0.

Source files
------------

// File: rtl/native_register_arbiter_if.sv
// ---------------------------------------------------------------------------
// native_register_arbiter_if
//
// Requester-side bus of the two-master register arbiter.
//
// Handshake: a requester raises req_N together with we_N/addr_N/wdata_N and
// holds all four steady until it sees ack_N. ack_N is a one-cycle pulse, and
// rdata_N is valid only in that cycle; outside it rdata_N reads 0.
//
// Signals (N = 0, 1)
//   req_N    requester -> arbiter  access request
//   we_N     requester -> arbiter  1 = write, 0 = read
//   addr_N   requester -> arbiter  register select (0 COUNT, 1 CONFIG,
//                                  2 FIFO, 3 STATUS)
//   wdata_N  requester -> arbiter  write data
//   ack_N    arbiter -> requester  one-cycle completion
//   rdata_N  arbiter -> requester  read data, qualified by ack_N
//
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface native_register_arbiter_if;
    logic        req_0;
    logic        we_0;
    logic [1:0]  addr_0;
    logic [31:0] wdata_0;
    logic        ack_0;
    logic [31:0] rdata_0;

    logic        req_1;
    logic        we_1;
    logic [1:0]  addr_1;
    logic [31:0] wdata_1;
    logic        ack_1;
    logic [31:0] rdata_1;

    modport master (
        output req_0, we_0, addr_0, wdata_0,
        output req_1, we_1, addr_1, wdata_1,
        input  ack_0, rdata_0,
        input  ack_1, rdata_1
    );

    modport slave (
        input  req_0, we_0, addr_0, wdata_0,
        input  req_1, we_1, addr_1, wdata_1,
        output ack_0, rdata_0,
        output ack_1, rdata_1
    );
endinterface

// File: rtl/native_register_arbiter.sv
// ---------------------------------------------------------------------------
// native_register_arbiter
//
// Two requesters share one native register block (counter, config bits and
// a byte FIFO). Each access runs IDLE -> ACCESS -> RESP: the winner's command
// is latched in IDLE, the native strobe fires in ACCESS, and the ack and read
// data are returned in RESP. Ties are broken round-robin, and requester 0 is
// favoured out of reset.
//
// Optional feature: define NATIVE_REGISTER_ARBITER_ERR_EN to add err_0/err_1.
// Each one pulses with its ack for a FIFO write while full, a FIFO read while
// empty, or a STATUS write.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   bus                 requester bus (native_register_arbiter_if.slave)
//   count_we, config_we, fifo_we, fifo_re   one-cycle native strobes
//   count_in, en_in, dir_in, ire_in, fifo_data_in
//                       native write data, held between strobes
//   count_out, en_out, dir_out, ire_out, lt_1k_out, fifo_empty, fifo_full,
//   fifo_word_count, fifo_data_out          native read-side inputs
//   err_0, err_1        access error flags (NATIVE_REGISTER_ARBITER_ERR_EN only)
//   state_o             current FSM state (debug)
// ---------------------------------------------------------------------------
module native_register_arbiter (
    input  logic                      clk,
    input  logic                      reset,
    native_register_arbiter_if.slave  bus,
    output logic                      count_we,
    output logic                      config_we,
    output logic                      fifo_we,
    output logic                      fifo_re,
    output logic [31:0]               count_in,
    output logic                      en_in,
    output logic                      dir_in,
    output logic                      ire_in,
    output logic [7:0]                fifo_data_in,
    input  logic [31:0]               count_out,
    input  logic                      en_out,
    input  logic                      dir_out,
    input  logic                      ire_out,
    input  logic                      lt_1k_out,
    input  logic                      fifo_empty,
    input  logic                      fifo_full,
    input  logic [7:0]                fifo_word_count,
    input  logic [7:0]                fifo_data_out,
`ifdef NATIVE_REGISTER_ARBITER_ERR_EN
    output logic                      err_0,
    output logic                      err_1,
`endif
    output logic [1:0]                state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] A_COUNT  = 2'd0;
    localparam logic [1:0] A_CONFIG = 2'd1;
    localparam logic [1:0] A_FIFO   = 2'd2;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;       // requester that owns the current access
    logic        pri_q, pri_d;       // requester that wins a tie
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;   // register read sampled in ACCESS
    logic        pop_q, pop_d;       // a FIFO pop was actually issued
    logic [31:0] count_in_q;
    logic [2:0]  cfg_in_q;
    logic [7:0]  fifo_data_in_q;
    logic        any_req;
    logic        winner;
    logic        ack;
    logic [31:0] rdata_sel;

    assign any_req = bus.req_0 | bus.req_1;
    assign winner  = (bus.req_0 & bus.req_1) ? pri_q : bus.req_1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        pri_d     = pri_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        pop_d     = pop_q;
        count_we  = 1'b0;
        config_we = 1'b0;
        fifo_we   = 1'b0;
        fifo_re   = 1'b0;
        ack       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                    gnt_d   = winner;
                    pri_d   = ~winner;
                    we_d    = winner ? bus.we_1    : bus.we_0;
                    addr_d  = winner ? bus.addr_1  : bus.addr_0;
                    wdata_d = winner ? bus.wdata_1 : bus.wdata_0;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                rdata_d = 32'd0;     // writes return zero data
                pop_d   = 1'b0;
                if (we_q) begin
                    // STATUS writes fall through with no strobe.
                    case (addr_q)
                        A_COUNT:  count_we  = 1'b1;
                        A_CONFIG: config_we = 1'b1;
                        A_FIFO:   fifo_we   = ~fifo_full;
                        default:  ;
                    endcase
                end else begin
                    case (addr_q)
                        A_COUNT:  rdata_d = count_out;
                        A_CONFIG: rdata_d = {28'd0, lt_1k_out, ire_out, dir_out, en_out};
                        A_FIFO: begin
                            fifo_re = ~fifo_empty;
                            pop_d   = ~fifo_empty;
                        end
                        default:  rdata_d = {16'd0, fifo_word_count, 6'd0, fifo_full, fifo_empty};
                    endcase
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ack     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset aborts an in-flight access in the same cycle it is asserted.
        if (!reset) begin
            count_we  = 1'b0;
            config_we = 1'b0;
            fifo_we   = 1'b0;
            fifo_re   = 1'b0;
            ack       = 1'b0;
        end
    end

    // Native data follows the latched write data while its strobe is high
    // and otherwise holds the value it last carried.
    assign count_in     = count_we  ? wdata_q        : count_in_q;
    assign en_in        = config_we ? wdata_q[0]     : cfg_in_q[0];
    assign dir_in       = config_we ? wdata_q[1]     : cfg_in_q[1];
    assign ire_in       = config_we ? wdata_q[2]     : cfg_in_q[2];
    assign fifo_data_in = fifo_we   ? wdata_q[7:0]   : fifo_data_in_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            gnt_q          <= 1'b0;
            pri_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 2'd0;
            wdata_q        <= 32'd0;
            rdata_q        <= 32'd0;
            pop_q          <= 1'b0;
            count_in_q     <= 32'd0;
            cfg_in_q       <= 3'd0;
            fifo_data_in_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            pri_q          <= pri_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            pop_q          <= pop_d;
            count_in_q     <= count_in;
            cfg_in_q       <= {ire_in, dir_in, en_in};
            fifo_data_in_q <= fifo_data_in;
        end
    end

    // FIFO data arrives the cycle after the pop, so it is taken live in RESP.
    assign rdata_sel = (!we_q && addr_q == A_FIFO) ?
                       (pop_q ? {24'd0, fifo_data_out} : 32'd0) : rdata_q;

    assign bus.ack_0   = ack & ~gnt_q;
    assign bus.ack_1   = ack &  gnt_q;
    assign bus.rdata_0 = bus.ack_0 ? rdata_sel : 32'd0;
    assign bus.rdata_1 = bus.ack_1 ? rdata_sel : 32'd0;
    assign state_o     = state_q;

`ifdef NATIVE_REGISTER_ARBITER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            err_q <= ( we_q && addr_q == A_FIFO && fifo_full)  ||
                     (!we_q && addr_q == A_FIFO && fifo_empty) ||
                     ( we_q && addr_q == 2'd3);
        end
    end

    assign err_0 = bus.ack_0 & err_q;
    assign err_1 = bus.ack_1 & err_q;
`endif
endmodule

// File: tb/tb_native_register_arbiter.sv
module tb_native_register_arbiter;
`ifdef NATIVE_REGISTER_ARBITER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    native_register_arbiter_if bus();

    logic        count_we, config_we, fifo_we, fifo_re;
    logic [31:0] count_in;
    logic        en_in, dir_in, ire_in;
    logic [7:0]  fifo_data_in;
    logic [31:0] count_out;
    logic        en_out, dir_out, ire_out, lt_1k_out, fifo_empty, fifo_full;
    logic [7:0]  fifo_word_count, fifo_data_out;
    logic        err_0, err_1;
    logic [1:0]  state_o;

    native_register_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .count_we        (count_we),
        .config_we       (config_we),
        .fifo_we         (fifo_we),
        .fifo_re         (fifo_re),
        .count_in        (count_in),
        .en_in           (en_in),
        .dir_in          (dir_in),
        .ire_in          (ire_in),
        .fifo_data_in    (fifo_data_in),
        .count_out       (count_out),
        .en_out          (en_out),
        .dir_out         (dir_out),
        .ire_out         (ire_out),
        .lt_1k_out       (lt_1k_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_word_count (fifo_word_count),
        .fifo_data_out   (fifo_data_out),
`ifdef NATIVE_REGISTER_ARBITER_ERR_EN
        .err_0           (err_0),
        .err_1           (err_1),
`endif
        .state_o         (state_o)
    );

`ifndef NATIVE_REGISTER_ARBITER_ERR_EN
    assign err_0 = 1'b0;
    assign err_1 = 1'b0;
`endif

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [67:0] exp_st_q[$];    // {cycle, strobe one-hot, data}
    logic [99:0] exp_ack_q[$];   // {cycle, ack1, ack0, rdata1, rdata0, err1, err0}

    bit          last_g;         // requester granted most recently
    bit          op_we[2];
    logic [1:0]  op_addr[2];
    logic [31:0] op_wdata[2];
    logic [7:0]  pop_val;        // byte the native FIFO presents after a pop
    bit          pop_pend;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Native FIFO model: new data appears one cycle after a pop.
    always @(negedge clk) pop_pend = fifo_re;
    always @(posedge clk) begin
        if (pop_pend) begin
            #1 fifo_data_out = pop_val;
        end
    end

    // Reference: what one access by requester 'who' must produce.
    task automatic expect_op(input bit who, input int ack_cyc);
        logic [3:0]  oh;
        logic [31:0] d;
        logic [31:0] rd;
        bit          e;
        oh = 4'd0; d = 32'd0; rd = 32'd0; e = 1'b0;
        if (op_we[who]) begin
            if (op_addr[who] == 2'd0) begin
                oh = 4'b0001; d = op_wdata[who];
            end else if (op_addr[who] == 2'd1) begin
                oh = 4'b0010; d = op_wdata[who] & 32'h7;
            end else if (op_addr[who] == 2'd2) begin
                if (fifo_full) e = 1'b1;
                else begin oh = 4'b0100; d = op_wdata[who] & 32'hFF; end
            end else begin
                e = 1'b1;
            end
        end else begin
            if (op_addr[who] == 2'd0)
                rd = count_out;
            else if (op_addr[who] == 2'd1)
                rd = 32'(en_out) + 32'(dir_out) * 2 + 32'(ire_out) * 4 + 32'(lt_1k_out) * 8;
            else if (op_addr[who] == 2'd2) begin
                if (fifo_empty) e = 1'b1;
                else begin oh = 4'b1000; rd = 32'(pop_val); end
            end else
                rd = 32'(fifo_word_count) * 256 + 32'(fifo_full) * 2 + 32'(fifo_empty);
        end
        if (!ERR_EN) e = 1'b0;
        if (oh != 4'd0) exp_st_q.push_back({32'(ack_cyc - 1), oh, d});
        if (who) exp_ack_q.push_back({32'(ack_cyc), 1'b1, 1'b0, rd, 32'd0, e, 1'b0});
        else     exp_ack_q.push_back({32'(ack_cyc), 1'b0, 1'b1, 32'd0, rd, 1'b0, e});
    endtask

    // ---------------- monitor ----------------
    logic [3:0]  m_oh;
    logic [31:0] m_d;
    always @(negedge clk) begin
        m_oh = {fifo_re, fifo_we, config_we, count_we};
        m_d  = count_we  ? count_in :
               config_we ? {29'd0, ire_in, dir_in, en_in} :
               fifo_we   ? {24'd0, fifo_data_in} : 32'd0;
        if (m_oh != 4'd0) begin
            if (exp_st_q.size() == 0) begin
                total++; bad++;
                $display("FAIL strobe_unexpected: got %0h at cycle %0d expected none", {m_oh, m_d}, cyc);
            end else
                check("strobe", 128'({32'(cyc), m_oh, m_d}), 128'(exp_st_q.pop_front()));
        end
        if (bus.ack_0 || bus.ack_1) begin
            if (exp_ack_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ack_unexpected: got ack1=%0b ack0=%0b at cycle %0d expected none",
                         bus.ack_1, bus.ack_0, cyc);
            end else
                check("ack", 128'({32'(cyc), bus.ack_1, bus.ack_0, bus.rdata_1, bus.rdata_0, err_1, err_0}),
                      128'(exp_ack_q.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    task automatic rand_native();
        count_out       = $urandom;
        {en_out, dir_out, ire_out, lt_1k_out} = 4'($urandom);
        fifo_empty      = 1'($urandom);
        fifo_full       = 1'($urandom);
        fifo_word_count = 8'($urandom);
        fifo_data_out   = 8'($urandom);
        pop_val         = fifo_data_out ^ 8'($urandom_range(1, 255));
        for (int i = 0; i < 2; i++) begin
            op_we[i]    = 1'($urandom);
            op_addr[i]  = 2'($urandom);
            op_wdata[i] = $urandom;
        end
    endtask

    // Called at a negedge while the DUT is idle; requests held until acked.
    task automatic run_batch(input bit r0, input bit r1);
        int k;
        int guard;
        bit first;
        bit done0;
        bit done1;
        k = cyc;
        first = (r0 && r1) ? ~last_g : r1;
        expect_op(first, k + 2);
        last_g = first;
        if (r0 && r1) begin
            expect_op(~first, k + 5);
            last_g = ~first;
        end
        bus.we_0 = op_we[0]; bus.addr_0 = op_addr[0]; bus.wdata_0 = op_wdata[0];
        bus.we_1 = op_we[1]; bus.addr_1 = op_addr[1]; bus.wdata_1 = op_wdata[1];
        bus.req_0 = r0;
        bus.req_1 = r1;
        done0 = !r0; done1 = !r1; guard = 0;
        while (!(done0 && done1) && guard < 20) begin
            @(negedge clk);
            guard++;
            if (bus.ack_0) begin done0 = 1'b1; bus.req_0 = 1'b0; end
            if (bus.ack_1) begin done1 = 1'b1; bus.req_1 = 1'b0; end
        end
        if (!(done0 && done1)) begin
            total++; bad++;
            $display("FAIL batch_timeout: got done0=%0b done1=%0b expected both acked", done0, done1);
            bus.req_0 = 1'b0;
            bus.req_1 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_state"}, 128'(state_o), 128'(2'd0));
        check({name, "_strobes"}, 128'({count_we, config_we, fifo_we, fifo_re}), 128'(4'd0));
        check({name, "_data"}, 128'({count_in, en_in, dir_in, ire_in, fifo_data_in}), 128'(0));
        check({name, "_ack"}, 128'({bus.ack_0, bus.ack_1, bus.rdata_0, bus.rdata_1, err_0, err_1}), 128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = 2'd0; bus.wdata_0 = 32'd0;
        bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = 2'd0; bus.wdata_1 = 32'd0;
        rand_native();
        last_g = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // both read COUNT from reset: grants 0,1 then 0,1 again
        for (int b = 0; b < 2; b++) begin
            rand_native();
            op_we[0] = 1'b0; op_addr[0] = 2'd0;
            op_we[1] = 1'b0; op_addr[1] = 2'd0;
            run_batch(1'b1, 1'b1);
        end

        // COUNT write of 1000
        rand_native();
        op_we[0] = 1'b1; op_addr[0] = 2'd0; op_wdata[0] = 32'h0000_03E8;
        run_batch(1'b1, 1'b0);

        // FIFO write while full
        rand_native();
        fifo_full = 1'b1;
        op_we[0] = 1'b1; op_addr[0] = 2'd2; op_wdata[0] = 32'h0000_00A5;
        run_batch(1'b1, 1'b0);

        // FIFO read returning 0x5C
        rand_native();
        fifo_empty = 1'b0; pop_val = 8'h5C; fifo_data_out = 8'h33;
        op_we[1] = 1'b0; op_addr[1] = 2'd2;
        run_batch(1'b0, 1'b1);

        // STATUS read: empty=0 full=1 word_count=0x10
        rand_native();
        fifo_empty = 1'b0; fifo_full = 1'b1; fifo_word_count = 8'h10;
        op_we[0] = 1'b0; op_addr[0] = 2'd3;
        run_batch(1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int sel;
            rand_native();
            sel = $urandom_range(1, 3);
            run_batch(sel[0], sel[1]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset during the ACCESS cycle of a CONFIG write
        rand_native();
        bus.we_0 = 1'b1; bus.addr_0 = 2'd1; bus.wdata_0 = 32'h0000_0007;
        bus.req_0 = 1'b1; bus.req_1 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req_0 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b1;
        last_g = 1'b1;
        @(negedge clk);

        // after reset requester 0 must win the tie
        rand_native();
        run_batch(1'b1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            int sel;
            rand_native();
            sel = $urandom_range(1, 3);
            run_batch(sel[0], sel[1]);
        end

        repeat (4) @(negedge clk);
        check("strobe_queue_empty", 128'(exp_st_q.size()), 128'(0));
        check("ack_queue_empty", 128'(exp_ack_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
